posiciona_porta_avioes: RTL and testbench

Placement controller for the aircraft carrier (porta-aviões, 5 cells) on the 8x8 board. Turns debounced player button pulses into a candidate ship position, enforces board bounds, checks the candidate against the occupancy map cell by cell, and drives the 64-bit `posicoesEmbarcacao` vector that the VGA ship renderer consumes. Sits between the input debouncer and the VGA ship-drawing stage.

---
 rtl/batalha_pkg.sv | 35 +++
 rtl/celula_ocupada.sv | 16 +
 rtl/posiciona_porta_avioes.sv | 146 ++++++++++++++
 tb/tb_posiciona_porta_avioes.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/batalha_pkg.sv
// Shared definitions for the battleship board: geometry, vector field layout,
// ship lengths, placement FSM states and the cell-to-bitmap index mapping.
package batalha_pkg;

  localparam int unsigned GRADE        = 8;
  localparam int unsigned COORD_W      = 4;
  localparam int unsigned IDX_W        = $clog2(GRADE * GRADE);
  localparam int unsigned CAMPO_X_MSB  = 6;
  localparam int unsigned CAMPO_Y_MSB  = 10;
  localparam int unsigned PASSO_CELULA = 8;

  localparam int unsigned TAM_PORTA_AVIOES = 5;
  localparam int unsigned TAM_ENCOURACADO  = 4;
  localparam int unsigned TAM_CRUZADOR     = 3;
  localparam int unsigned TAM_SUBMARINO    = 2;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EDIT,
    S_CHECK,
    S_DONE
  } estado_t;

  // Coordinates are 1-based; bitmap bit (y-1)*GRADE + (x-1)
  function automatic logic [IDX_W-1:0] indice_celula(input coord_t x, input coord_t y);
    coord_t xm1;
    coord_t ym1;
    xm1 = x - 1'b1;
    ym1 = y - 1'b1;
    return IDX_W'(int'(ym1) * GRADE + int'(xm1));
  endfunction

endpackage

// File: rtl/celula_ocupada.sv
// Looks up the occupancy bit of a single board cell given its 1-based (x,y).
module celula_ocupada
  import batalha_pkg::*;
(
  input  coord_t                   i_x,
  input  coord_t                   i_y,
  input  logic [GRADE*GRADE-1:0]   i_ocupado,
  output logic                     o_ocupada
);

  logic [IDX_W-1:0] w_indice;

  assign w_indice  = indice_celula(i_x, i_y);
  assign o_ocupada = i_ocupado[w_indice];

endmodule

// File: rtl/posiciona_porta_avioes.sv
// Aircraft-carrier placement controller: button-driven anchor/orientation editing,
// cell-by-cell overlap check against the occupancy map, registered position vector.
module posiciona_porta_avioes #(
  parameter int unsigned TAM   = 5,
  parameter int unsigned GRADE = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iniciar,
  input  logic                     btn_cima,
  input  logic                     btn_baixo,
  input  logic                     btn_esq,
  input  logic                     btn_dir,
  input  logic                     btn_girar,
  input  logic                     btn_confirmar,
  input  logic [GRADE*GRADE-1:0]   ocupado,
  output logic [63:0]              posicoesEmbarcacao,
  output logic                     editando,
  output logic                     pronto,
  output logic                     rejeitado
);

  import batalha_pkg::*;

  localparam int unsigned K_W   = $clog2(TAM);
  localparam coord_t      LIM   = coord_t'(GRADE - TAM + 1);
  localparam coord_t      GMAX  = coord_t'(GRADE);
  localparam logic [K_W-1:0] K_ULT = K_W'(TAM - 1);

  estado_t          r_estado, w_estado;
  coord_t           r_x0, r_y0, w_x0, w_y0;
  logic             r_vert, w_vert;
  logic [K_W-1:0]   r_k, w_k;
  logic [63:0]      r_vetor, w_vetor;
  logic             r_editando, r_pronto, r_rejeitado, w_rej;

  coord_t           w_cx, w_cy, w_lim_x, w_lim_y;
  logic             w_hit;

  function automatic logic [63:0] montar_vetor(input coord_t x0, input coord_t y0,
                                               input logic vert, input logic fixo);
    logic [63:0] v;
    v = '0;
    for (int unsigned k = 0; k < TAM; k++) begin
      v[CAMPO_X_MSB + PASSO_CELULA*k -: COORD_W] = vert ? x0 : x0 + coord_t'(k);
      v[CAMPO_Y_MSB + PASSO_CELULA*k -: COORD_W] = vert ? y0 + coord_t'(k) : y0;
    end
    v[0] = fixo;
    return v;
  endfunction

  assign w_cx = r_vert ? r_x0 : r_x0 + coord_t'(r_k);
  assign w_cy = r_vert ? r_y0 + coord_t'(r_k) : r_y0;

  celula_ocupada u_celula (
    .i_x       (w_cx),
    .i_y       (w_cy),
    .i_ocupado (ocupado),
    .o_ocupada (w_hit)
  );

  assign w_lim_x = r_vert ? GMAX : LIM;
  assign w_lim_y = r_vert ? LIM  : GMAX;

  // iniciar restarts from any state, so it is handled ahead of the per-state logic
  always_comb begin
    w_estado = r_estado;
    w_x0     = r_x0;
    w_y0     = r_y0;
    w_vert   = r_vert;
    w_k      = r_k;
    w_rej    = 1'b0;
    if (iniciar) begin
      w_estado = S_EDIT;
      w_x0     = coord_t'(1);
      w_y0     = coord_t'(1);
      w_vert   = 1'b0;
      w_k      = '0;
    end else begin
      case (r_estado)
        S_EDIT: begin
          if (btn_confirmar) begin
            w_estado = S_CHECK;
            w_k      = '0;
          end else if (btn_girar) begin
            w_vert = ~r_vert;
            if (!r_vert && r_y0 > LIM) w_y0 = LIM;
            if (r_vert && r_x0 > LIM)  w_x0 = LIM;
          end else if (btn_cima) begin
            if (r_y0 < w_lim_y) w_y0 = r_y0 + 1'b1;
          end else if (btn_baixo) begin
            if (r_y0 > coord_t'(1)) w_y0 = r_y0 - 1'b1;
          end else if (btn_esq) begin
            if (r_x0 > coord_t'(1)) w_x0 = r_x0 - 1'b1;
          end else if (btn_dir) begin
            if (r_x0 < w_lim_x) w_x0 = r_x0 + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_hit) begin
            w_estado = S_EDIT;
            w_rej    = 1'b1;
          end else if (r_k == K_ULT) begin
            w_estado = S_DONE;
          end else begin
            w_k = r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_vetor = (w_estado == S_IDLE) ? '0
                 : montar_vetor(w_x0, w_y0, w_vert, w_estado == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado    <= S_IDLE;
      r_x0        <= coord_t'(1);
      r_y0        <= coord_t'(1);
      r_vert      <= 1'b0;
      r_k         <= '0;
      r_vetor     <= '0;
      r_editando  <= 1'b0;
      r_pronto    <= 1'b0;
      r_rejeitado <= 1'b0;
    end else begin
      r_estado    <= w_estado;
      r_x0        <= w_x0;
      r_y0        <= w_y0;
      r_vert      <= w_vert;
      r_k         <= w_k;
      r_vetor     <= w_vetor;
      r_editando  <= (w_estado == S_EDIT);
      r_pronto    <= (w_estado == S_DONE);
      r_rejeitado <= w_rej;
    end
  end

  assign posicoesEmbarcacao = r_vetor;
  assign editando           = r_editando;
  assign pronto             = r_pronto;
  assign rejeitado          = r_rejeitado;

endmodule

// File: tb/tb_posiciona_porta_avioes.sv
// Scoreboard bench for the carrier placement controller: directed stimulus queues
// cycle-stamped expectations, a negedge monitor pops and compares them.
module tb_posiciona_porta_avioes;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0, btn_cima = 1'b0, btn_baixo = 1'b0, btn_esq = 1'b0;
  logic        btn_dir = 1'b0, btn_girar = 1'b0, btn_confirmar = 1'b0;
  logic [63:0] ocupado = '0;
  logic [63:0] posicoesEmbarcacao;
  logic        editando, pronto, rejeitado;

  localparam logic [6:0] B_INI  = 7'd1;
  localparam logic [6:0] B_CIMA = 7'd2;
  localparam logic [6:0] B_BAIX = 7'd4;
  localparam logic [6:0] B_ESQ  = 7'd8;
  localparam logic [6:0] B_DIR  = 7'd16;
  localparam logic [6:0] B_GIR  = 7'd32;
  localparam logic [6:0] B_CONF = 7'd64;

  localparam int ST_IDLE = 0, ST_EDIT = 1, ST_CHECK = 2, ST_DONE = 3;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fails = 0;
  int          cyc_q[$];
  logic [66:0] val_q[$];
  string       nm_q[$];
  int          rej_q[$];

  int          e_cyc;
  logic [66:0] e_val;
  string       e_nm;

  posiciona_porta_avioes #(.TAM(5), .GRADE(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .iniciar            (iniciar),
    .btn_cima           (btn_cima),
    .btn_baixo          (btn_baixo),
    .btn_esq            (btn_esq),
    .btn_dir            (btn_dir),
    .btn_girar          (btn_girar),
    .btn_confirmar      (btn_confirmar),
    .ocupado            (ocupado),
    .posicoesEmbarcacao (posicoesEmbarcacao),
    .editando           (editando),
    .pronto             (pronto),
    .rejeitado          (rejeitado)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Each cell occupies one byte at bit 3+8k: X in the low nibble, Y in the high nibble
  function automatic logic [63:0] exp_vec(input logic [3:0] x0, input logic [3:0] y0,
                                          input logic v, input logic done);
    logic [63:0] r;
    logic [7:0]  cel;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      cel[3:0] = v ? x0 : x0 + 4'(k);
      cel[7:4] = v ? y0 + 4'(k) : y0;
      r = r | (64'(cel) << (3 + 8*k));
    end
    r[0] = done;
    return r;
  endfunction

  task automatic push_exp(input int c, input string nm, input logic [3:0] x, input logic [3:0] y,
                          input logic v, input int st, input logic rej);
    logic [63:0] vec;
    vec = (st == ST_IDLE) ? 64'd0 : exp_vec(x, y, v, st == ST_DONE);
    cyc_q.push_back(c);
    nm_q.push_back(nm);
    val_q.push_back({vec, st == ST_EDIT, st == ST_DONE, rej});
  endtask

  task automatic set_btn(input logic [6:0] b);
    iniciar       = b[0];
    btn_cima      = b[1];
    btn_baixo     = b[2];
    btn_esq       = b[3];
    btn_dir       = b[4];
    btn_girar     = b[5];
    btn_confirmar = b[6];
  endtask

  task automatic act(input logic [6:0] b, input string nm, input logic [3:0] x,
                     input logic [3:0] y, input logic v, input int st);
    set_btn(b);
    push_exp(cyc + 1, nm, x, y, v, st, 1'b0);
    @(negedge clk);
    set_btn(7'd0);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      e_cyc = cyc_q.pop_front();
      e_val = val_q.pop_front();
      e_nm  = nm_q.pop_front();
      n_checks++;
      if (e_cyc < cyc) begin
        n_fails++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e_nm, e_cyc, cyc);
      end else if ({posicoesEmbarcacao, editando, pronto, rejeitado} !== e_val) begin
        n_fails++;
        $display("FAIL %s @%0d: got vec=%h ed=%b pr=%b rej=%b, want vec=%h ed=%b pr=%b rej=%b",
                 e_nm, cyc, posicoesEmbarcacao, editando, pronto, rejeitado,
                 e_val[66:3], e_val[2], e_val[1], e_val[0]);
      end
    end
    if (rejeitado === 1'b1) begin
      n_checks++;
      if (rej_q.size() > 0 && rej_q[0] == cyc) void'(rej_q.pop_front());
      else begin
        n_fails++;
        $display("FAIL rej_pulse @%0d: got rejeitado=1, want 0", cyc);
      end
    end else if (rej_q.size() > 0 && rej_q[0] <= cyc) begin
      n_checks++;
      n_fails++;
      $display("FAIL rej_pulse @%0d: got rejeitado=%b, want 1 at cycle %0d", cyc, rejeitado, rej_q[0]);
      void'(rej_q.pop_front());
    end
  end

  int c;

  initial begin
    set_btn(7'd0);
    @(negedge clk);
    @(negedge clk);
    push_exp(cyc + 1, "reset", 1, 1, 0, ST_IDLE, 0);
    @(negedge clk);
    reset = 1'b0;

    act(B_DIR, "idle_ignora", 1, 1, 0, ST_IDLE);
    act(B_INI, "iniciar", 1, 1, 0, ST_EDIT);
    act(B_DIR, "dir1", 2, 1, 0, ST_EDIT);
    act(B_DIR, "dir2", 3, 1, 0, ST_EDIT);
    act(B_DIR, "dir3", 4, 1, 0, ST_EDIT);
    act(B_DIR, "dir_limite", 4, 1, 0, ST_EDIT);
    act(B_DIR, "dir_limite2", 4, 1, 0, ST_EDIT);
    act(B_GIR, "girar_v", 4, 1, 1, ST_EDIT);
    act(B_CIMA, "cima_v1", 4, 2, 1, ST_EDIT);
    act(B_CIMA, "cima_v2", 4, 3, 1, ST_EDIT);
    act(B_CIMA, "cima_v3", 4, 4, 1, ST_EDIT);
    act(B_CIMA, "cima_limite_v", 4, 4, 1, ST_EDIT);
    act(B_GIR, "girar_h", 4, 4, 0, ST_EDIT);
    act(B_CIMA, "cima_h1", 4, 5, 0, ST_EDIT);
    act(B_CIMA, "cima_h2", 4, 6, 0, ST_EDIT);
    act(B_GIR, "clamp_y", 4, 4, 1, ST_EDIT);
    act(B_DIR, "dir_v1", 5, 4, 1, ST_EDIT);
    act(B_DIR, "dir_v2", 6, 4, 1, ST_EDIT);
    act(B_DIR, "dir_v3", 7, 4, 1, ST_EDIT);
    act(B_DIR, "dir_v4", 8, 4, 1, ST_EDIT);
    act(B_DIR, "dir_limite_v", 8, 4, 1, ST_EDIT);
    act(B_GIR, "clamp_x", 4, 4, 0, ST_EDIT);
    act(B_BAIX, "baixo1", 4, 3, 0, ST_EDIT);
    act(B_BAIX, "baixo2", 4, 2, 0, ST_EDIT);
    act(B_BAIX, "baixo3", 4, 1, 0, ST_EDIT);
    act(B_BAIX, "baixo_limite", 4, 1, 0, ST_EDIT);
    act(B_ESQ, "esq1", 3, 1, 0, ST_EDIT);
    act(B_ESQ, "esq2", 2, 1, 0, ST_EDIT);
    act(B_ESQ, "esq3", 1, 1, 0, ST_EDIT);
    act(B_ESQ, "esq_limite", 1, 1, 0, ST_EDIT);
    act(B_CIMA | B_DIR | B_GIR, "prio_girar", 1, 1, 1, ST_EDIT);
    act(B_GIR, "girar_h2", 1, 1, 0, ST_EDIT);
    act(B_CIMA | B_BAIX, "prio_cima", 1, 2, 0, ST_EDIT);
    act(B_BAIX, "baixo4", 1, 1, 0, ST_EDIT);
    act(B_ESQ | B_DIR, "prio_esq", 1, 1, 0, ST_EDIT);

    // Overlap on cell (3,1), k=2
    ocupado = 64'h4;
    c = cyc;
    set_btn(B_CONF);
    push_exp(c + 1, "check_entra", 1, 1, 0, ST_CHECK, 0);
    push_exp(c + 4, "rejeita_k2", 1, 1, 0, ST_EDIT, 1);
    push_exp(c + 5, "rejeita_fim", 1, 1, 0, ST_EDIT, 0);
    rej_q.push_back(c + 4);
    @(negedge clk);
    set_btn(B_DIR | B_GIR);
    @(negedge clk);
    set_btn(7'd0);
    wait_until(c + 5);

    // Vertical anchor (2,2): overlap on last cell (2,6), bit 41
    act(B_INI, "reinicia", 1, 1, 0, ST_EDIT);
    act(B_GIR, "girar_v2", 1, 1, 1, ST_EDIT);
    act(B_DIR, "dir_v5", 2, 1, 1, ST_EDIT);
    act(B_CIMA, "cima_v4", 2, 2, 1, ST_EDIT);
    ocupado = (64'h1 << 41) | 64'h4;
    c = cyc;
    set_btn(B_CONF);
    push_exp(c + 1, "check_v_entra", 2, 2, 1, ST_CHECK, 0);
    push_exp(c + 5, "check_v_k3", 2, 2, 1, ST_CHECK, 0);
    push_exp(c + 6, "rejeita_k4", 2, 2, 1, ST_EDIT, 1);
    rej_q.push_back(c + 6);
    @(negedge clk);
    set_btn(7'd0);
    wait_until(c + 6);

    // iniciar aborts a check in progress
    ocupado = '0;
    c = cyc;
    set_btn(B_CONF);
    push_exp(c + 1, "check_aborto", 2, 2, 1, ST_CHECK, 0);
    push_exp(c + 3, "aborta_check", 1, 1, 0, ST_EDIT, 0);
    push_exp(c + 7, "sem_pronto", 1, 1, 0, ST_EDIT, 0);
    @(negedge clk);
    set_btn(7'd0);
    @(negedge clk);
    set_btn(B_INI);
    @(negedge clk);
    set_btn(7'd0);
    wait_until(c + 7);

    // Clean pass with neighbouring cells (6,1) and (1,2) occupied
    ocupado = 64'h120;
    c = cyc;
    set_btn(B_CONF);
    push_exp(c + 1, "check_ok_entra", 1, 1, 0, ST_CHECK, 0);
    push_exp(c + 5, "check_ok_k3", 1, 1, 0, ST_CHECK, 0);
    push_exp(c + 6, "pronto", 1, 1, 0, ST_DONE, 0);
    push_exp(c + 7, "done_ignora", 1, 1, 0, ST_DONE, 0);
    @(negedge clk);
    set_btn(B_GIR);
    @(negedge clk);
    set_btn(7'd0);
    wait_until(c + 6);
    set_btn(B_DIR | B_CONF | B_GIR);
    @(negedge clk);
    set_btn(7'd0);
    act(B_INI, "reabre", 1, 1, 0, ST_EDIT);

    // Reset in the middle of a check
    ocupado = '0;
    c = cyc;
    set_btn(B_CONF);
    push_exp(c + 1, "check_reset", 1, 1, 0, ST_CHECK, 0);
    push_exp(c + 3, "reset_check", 1, 1, 0, ST_IDLE, 0);
    @(negedge clk);
    set_btn(7'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    act(B_DIR, "idle_pos_reset", 1, 1, 0, ST_IDLE);
    act(B_INI, "pos_reset", 1, 1, 0, ST_EDIT);

    repeat (3) @(negedge clk);
    while (cyc_q.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: expectation for cycle %0d never checked", nm_q[0], cyc_q[0]);
      void'(cyc_q.pop_front());
      void'(nm_q.pop_front());
      void'(val_q.pop_front());
    end
    while (rej_q.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL rej_pulse: expected pulse at cycle %0d never seen", rej_q[0]);
      void'(rej_q.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
